if_id_skid_reg: RTL and testbench
=================================

IF_ID_SKID_REG -- requirements
Module: if_id_skid_reg

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0000, instruction word presented on Out_Instr when no valid entry is held.
REQ-002 Clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Rst  input  1  synchronous, active-low reset.
REQ-004 In_Valid  input  1  fetch stage presents a valid instruction this cycle.
REQ-005 In_Ready  output  1  block can accept an instruction; when low, the fetch stage holds its PC.
REQ-006 In_Instr  input  32  fetched instruction from instruction memory.
REQ-007 In_PCI  input  32  PC+4 of the fetched instruction.
REQ-008 Flush  input  1  taken branch or jump; discard all wrong-path entries.
REQ-009 Out_Valid  output  1  Out_Instr/Out_PCI hold a valid entry.
REQ-010 Out_Ready  input  1  decode stage accepts the entry this cycle (low = decode stall).
REQ-011 Out_Instr  output  32  instruction to decode.
REQ-012 Out_PCI  output  32  PC+4 paired with Out_Instr.
REQ-013 Stall_Cnt  output  16  count of decode-stall cycles (see Configuration).

Function
REQ-014 Input transfer SHALL occur when In_Valid & In_Ready; output transfer when Out_Valid & Out_Ready.
REQ-015 The block SHALL hold two entries, main and skid, with states EMPTY, ONE, TWO.
REQ-016 In_Ready SHALL be 1 in EMPTY and ONE, and 0 in TWO, and SHALL be decoded from the state register only, with no combinational path from Out_Ready.
REQ-017 Out_Valid SHALL be 1 in ONE and TWO; Out_Instr/Out_PCI SHALL come from the main register, with Out_Instr = NOP_INSTR and Out_PCI = 0 in EMPTY.
REQ-018 EMPTY: input transfer -> ONE, main <= input; otherwise stay.
REQ-019 ONE: input only -> TWO, skid <= input; output only -> EMPTY; both -> ONE, main <= input; neither -> hold.
REQ-020 TWO: output transfer -> ONE, main <= skid; otherwise hold.
REQ-021 Latency: an entry accepted in cycle N SHALL appear on the outputs in cycle N+1 when the block was EMPTY, or when the block was ONE with a simultaneous output transfer.
REQ-022 While Out_Valid & !Out_Ready, Out_Instr and Out_PCI SHALL remain stable.
REQ-023 Entries SHALL leave in acceptance order; no entry is duplicated or dropped except by Flush or reset.
REQ-024 Flush SHALL override all transitions: next state is EMPTY, and both entries plus any same-cycle input transfer are discarded.
REQ-025 In the Flush cycle, outputs SHALL still show the current entry; decode treats it per its own hazard logic.
REQ-026 In_Ready SHALL be 1 in the cycle after a Flush.

Reset
REQ-027 When Rst = 0 at a rising edge, the next state SHALL be EMPTY with Out_Valid = 0, In_Ready = 1, Out_Instr = NOP_INSTR, Out_PCI = 0, and Stall_Cnt = 0.
REQ-028 Reset SHALL take priority over Flush and all handshakes, and SHALL discard held entries mid-operation.
REQ-029 The main and skid data registers need not be reset; outputs are masked by state.

Configuration
REQ-030 Macro IFID_STALL_CNT_EN: when defined, Stall_Cnt SHALL increment by 1 each cycle with Out_Valid & !Out_Ready, saturate at 16'hFFFF, and be unaffected by Flush.
REQ-031 Without IFID_STALL_CNT_EN, the Stall_Cnt port SHALL remain present and be driven constant 16'h0000, with no counter logic.

Verification
REQ-032 Reset then stream: In_Valid = 1 with In_Instr = 32'h2008_0005, 32'h2009_0007 on consecutive cycles, Out_Ready = 1 -> outputs show each one cycle later, In_Ready stays 1, and state stays ONE.
REQ-033 Stall fill: two inputs accepted with Out_Ready = 0 -> state TWO, In_Ready = 0 from the following cycle, and Out_Instr holds the first word; raise Out_Ready -> first word then second word, each for one cycle.
REQ-034 Flush in TWO with In_Valid = 1 -> next cycle Out_Valid = 0, Out_Instr = NOP_INSTR, In_Ready = 1; none of the three words ever reappear.
REQ-035 Simultaneous in/out in ONE (Out_Ready = 1, In_Valid = 1, In_PCI = 32'h0000_0010) -> next cycle Out_PCI = 32'h0000_0010 and state ONE.
REQ-036 Rst = 0 asserted in TWO during Flush -> next cycle EMPTY with all outputs at reset values; with IFID_STALL_CNT_EN, Stall_Cnt = 0.
REQ-037 With IFID_STALL_CNT_EN: hold Out_Valid = 1, Out_Ready = 0 for 70000 cycles -> Stall_Cnt = 16'hFFFF and it stays there; without the macro -> Stall_Cnt = 0 throughout.

Source files
------------

// File: rtl/if_id_skid_reg_if.sv
// Handshake and data bundle between fetch, the IF/ID skid register and decode.
// In_* faces the fetch stage, Out_* faces decode, and Flush comes from branch resolution.
interface if_id_skid_reg_if;
    logic        In_Valid;
    logic        In_Ready;
    logic [31:0] In_Instr;
    logic [31:0] In_PCI;
    logic        Flush;
    logic        Out_Valid;
    logic        Out_Ready;
    logic [31:0] Out_Instr;
    logic [31:0] Out_PCI;

    // Skid register side.
    modport slave (
        input  In_Valid, In_Instr, In_PCI, Flush, Out_Ready,
        output In_Ready, Out_Valid, Out_Instr, Out_PCI
    );

    // Surrounding pipeline side: fetch, decode and flush source.
    modport master (
        output In_Valid, In_Instr, In_PCI, Flush, Out_Ready,
        input  In_Ready, Out_Valid, Out_Instr, Out_PCI
    );
endinterface

// File: rtl/if_id_skid_reg.sv
// Two-entry IF/ID pipeline register (main + skid) with a registered In_Ready.
// Optional decode-stall counter, enabled by defining IFID_STALL_CNT_EN.
//
// Handshake: a transfer happens on a rising Clk edge where valid & ready are both 1.
// The source holds valid and data stable until that transfer happens.
// In_Ready is decoded from state_q only, so it has no combinational path from Out_Ready.
module if_id_skid_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                  Clk,
    input  logic                  Rst,
    if_id_skid_reg_if.slave       bus,
    output logic [15:0]           Stall_Cnt,
    output logic [1:0]            state_dbg
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] main_instr_q, main_instr_d;
    logic [31:0] main_pci_q,   main_pci_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pci_q,   skid_pci_d;

    logic in_ready;
    logic out_valid;
    logic in_xfer;
    logic out_xfer;

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign in_xfer   = bus.In_Valid & in_ready;
    assign out_xfer  = out_valid & bus.Out_Ready;

    assign bus.In_Ready  = in_ready;
    assign bus.Out_Valid = out_valid;
    assign bus.Out_Instr = out_valid ? main_instr_q : NOP_INSTR;
    assign bus.Out_PCI   = out_valid ? main_pci_q   : 32'h0000_0000;
    assign state_dbg     = state_q;

    always_comb begin
        state_d      = state_q;
        main_instr_d = main_instr_q;
        main_pci_d   = main_pci_q;
        skid_instr_d = skid_instr_q;
        skid_pci_d   = skid_pci_q;

        unique case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d      = ONE;
                    main_instr_d = bus.In_Instr;
                    main_pci_d   = bus.In_PCI;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_instr_d = bus.In_Instr;
                    main_pci_d   = bus.In_PCI;
                end else if (in_xfer) begin
                    state_d      = TWO;
                    skid_instr_d = bus.In_Instr;
                    skid_pci_d   = bus.In_PCI;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_d      = ONE;
                    main_instr_d = skid_instr_q;
                    main_pci_d   = skid_pci_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // A taken branch drops everything held plus whatever fetch offers this cycle.
        if (bus.Flush) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data words are masked by state on the outputs, so they carry no reset.
    always_ff @(posedge Clk) begin
        main_instr_q <= main_instr_d;
        main_pci_q   <= main_pci_d;
        skid_instr_q <= skid_instr_d;
        skid_pci_q   <= skid_pci_d;
    end

`ifdef IFID_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !bus.Out_Ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_Cnt = stall_cnt_q;
`else
    assign Stall_Cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg: streaming, stall fill, flush, reset and stall counter.
// Inputs change 1ns after a rising edge and outputs are checked in that same window.
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [1:0]  S_EMPTY = 2'd0;
    localparam logic [1:0]  S_ONE   = 2'd1;
    localparam logic [1:0]  S_TWO   = 2'd2;
`ifdef IFID_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] stall_cnt;
    logic [1:0]  state_dbg;
    int          total;
    int          bad;

    if_id_skid_reg_if bus ();

    if_id_skid_reg #(.NOP_INSTR(NOP)) dut (
        .Clk       (clk),
        .Rst       (rst),
        .bus       (bus.slave),
        .Stall_Cnt (stall_cnt),
        .state_dbg (state_dbg)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
        return CNT_EN ? 32'(n) : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pci,
                         input logic fl, input logic ordy);
        bus.In_Valid  = v;
        bus.In_Instr  = instr;
        bus.In_PCI    = pci;
        bus.Flush     = fl;
        bus.Out_Ready = ordy;
    endtask

    task automatic check_out(input string tag, input logic [1:0] st, input logic ov,
                             input logic ir, input logic [31:0] instr, input logic [31:0] pci);
        check({tag, "_state"}, 32'(state_dbg), 32'(st));
        check({tag, "_ovalid"}, 32'(bus.Out_Valid), 32'(ov));
        check({tag, "_iready"}, 32'(bus.In_Ready), 32'(ir));
        check({tag, "_instr"}, bus.Out_Instr, instr);
        check({tag, "_pci"}, bus.Out_PCI, pci);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        tick();
        check_out("reset", S_EMPTY, 1'b0, 1'b1, NOP, 32'h0);
        check("reset_cnt", 32'(stall_cnt), 32'h0);

        // Streaming with decode always ready.
        rst = 1'b1;
        drive(1'b1, 32'h2008_0005, 32'h0000_0004, 1'b0, 1'b1);
        tick();
        check_out("strm_a", S_ONE, 1'b1, 1'b1, 32'h2008_0005, 32'h0000_0004);
        drive(1'b1, 32'h2009_0007, 32'h0000_0008, 1'b0, 1'b1);
        tick();
        check_out("strm_b", S_ONE, 1'b1, 1'b1, 32'h2009_0007, 32'h0000_0008);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        check_out("strm_drain", S_EMPTY, 1'b0, 1'b1, NOP, 32'h0);

        // Stall fill into the skid entry.
        drive(1'b1, 32'h1111_0001, 32'h0000_000C, 1'b0, 1'b0);
        tick();
        check_out("fill_c", S_ONE, 1'b1, 1'b1, 32'h1111_0001, 32'h0000_000C);
        drive(1'b1, 32'h2222_0002, 32'h0000_0010, 1'b0, 1'b0);
        tick();
        check_out("fill_d", S_TWO, 1'b1, 1'b0, 32'h1111_0001, 32'h0000_000C);
        drive(1'b1, 32'h3333_0003, 32'h0000_0014, 1'b0, 1'b0);
        tick();
        check_out("fill_hold", S_TWO, 1'b1, 1'b0, 32'h1111_0001, 32'h0000_000C);
        check("fill_cnt", 32'(stall_cnt), exp_cnt(2));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        check_out("fill_out_d", S_ONE, 1'b1, 1'b1, 32'h2222_0002, 32'h0000_0010);
        tick();
        check_out("fill_empty", S_EMPTY, 1'b0, 1'b1, NOP, 32'h0);
        check("fill_cnt2", 32'(stall_cnt), exp_cnt(2));

        // Flush while full with a same-cycle input offered.
        drive(1'b1, 32'h4444_0004, 32'h0000_0020, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h5555_0005, 32'h0000_0024, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'h6666_0006, 32'h0000_0028, 1'b1, 1'b0);
        #1;
        check_out("flush_cur", S_TWO, 1'b1, 1'b0, 32'h4444_0004, 32'h0000_0020);
        tick();
        check_out("flush_next", S_EMPTY, 1'b0, 1'b1, NOP, 32'h0);
        check("flush_cnt", 32'(stall_cnt), exp_cnt(4));
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        tick();
        check_out("flush_quiet", S_EMPTY, 1'b0, 1'b1, NOP, 32'h0);

        // Simultaneous accept and retire while holding one entry.
        drive(1'b1, 32'h7777_0007, 32'h0000_000C, 1'b0, 1'b1);
        tick();
        check_out("sim_i", S_ONE, 1'b1, 1'b1, 32'h7777_0007, 32'h0000_000C);
        drive(1'b1, 32'h8888_0008, 32'h0000_0010, 1'b0, 1'b1);
        tick();
        check_out("sim_j", S_ONE, 1'b1, 1'b1, 32'h8888_0008, 32'h0000_0010);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        tick();
        check_out("sim_drain", S_EMPTY, 1'b0, 1'b1, NOP, 32'h0);

        // Reset beats Flush and discards a full register.
        drive(1'b1, 32'h9999_0009, 32'h0000_0030, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hAAAA_000A, 32'h0000_0034, 1'b0, 1'b0);
        tick();
        check_out("rst_full", S_TWO, 1'b1, 1'b0, 32'h9999_0009, 32'h0000_0030);
        check("rst_full_cnt", 32'(stall_cnt), exp_cnt(5));
        rst = 1'b0;
        drive(1'b1, 32'hBBBB_000B, 32'h0000_0038, 1'b1, 1'b1);
        tick();
        check_out("rst_mid", S_EMPTY, 1'b0, 1'b1, NOP, 32'h0);
        check("rst_mid_cnt", 32'(stall_cnt), 32'h0);
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        check_out("rst_after", S_EMPTY, 1'b0, 1'b1, NOP, 32'h0);

        // Long decode stall: counter saturates (or stays zero without the counter).
        drive(1'b1, 32'hCCCC_000C, 32'h0000_0040, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (5) tick();
        check("sat_early", 32'(stall_cnt), exp_cnt(5));
        repeat (69995) tick();
        check("sat_full", 32'(stall_cnt), exp_cnt(16'hFFFF));
        repeat (10) tick();
        check("sat_hold", 32'(stall_cnt), exp_cnt(16'hFFFF));
        check_out("sat_entry", S_ONE, 1'b1, 1'b1, 32'hCCCC_000C, 32'h0000_0040);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
